unary_alu_sequencer: RTL and testbench

//  Issuing side of the unary ALU control interface: accepts operation requests
//  (opcode + operand) over a valid/ready handshake and decodes each opcode into
//  z/n control plus operand for an external combinational unary ALU.

---
 rtl/unary_alu_sequencer.sv | 147 ++++++++++++++
 tb/tb_unary_alu_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/unary_alu_sequencer.sv
// Unary ALU sequencer: accepts op requests, drives an external unary ALU,
// post-processes the result and returns it with status flags.
module unary_alu_sequencer #(
  parameter int BUS_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_req_valid,
  output logic                 o_req_ready,
  input  logic [2:0]           i_req_op,
  input  logic [BUS_WIDTH-1:0] i_req_data,
  output logic                 o_alu_z,
  output logic                 o_alu_n,
  output logic [BUS_WIDTH-1:0] o_alu_X,
  input  logic [BUS_WIDTH-1:0] i_alu_O,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [BUS_WIDTH-1:0] o_rsp_data,
  output logic                 o_rsp_zero,
  output logic                 o_rsp_neg,
  output logic                 o_rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_INC,
    S_RESP
  } state_e;

  localparam logic [2:0] OP_PASS = 3'd0;
  localparam logic [2:0] OP_NOT  = 3'd1;
  localparam logic [2:0] OP_ZERO = 3'd2;
  localparam logic [2:0] OP_ONES = 3'd3;
  localparam logic [2:0] OP_NEG  = 3'd4;

  localparam logic [BUS_WIDTH-1:0] ONE =
    {{(BUS_WIDTH-1){1'b0}}, 1'b1};

  state_e               state_q, state_d;
  logic [2:0]           op_q, op_d;
  logic [BUS_WIDTH-1:0] x_q, x_d;
  logic [BUS_WIDTH-1:0] res_q, res_d;
  logic                 err_q, err_d;
  logic                 rdy_q, rdy_d;

  logic req_fire;
  logic rsp_fire;
  logic op_legal;

  assign req_fire = i_req_valid & rdy_q;
  assign rsp_fire = (state_q == S_RESP) & i_rsp_ready;
  assign op_legal = (i_req_op <= OP_NEG);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      x_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      x_q     <= x_d;
      res_q   <= res_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_fire) begin
          state_d = op_legal ? S_DRIVE : S_RESP;
        end
      end
      S_DRIVE: begin
        state_d = (op_q == OP_NEG) ? S_INC : S_RESP;
      end
      S_INC: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_fire) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers; ready tracks the next state so it lags reset by one cycle.
  always_comb begin
    op_d  = op_q;
    x_d   = x_q;
    res_d = res_q;
    err_d = err_q;
    rdy_d = (state_d == S_IDLE);
    if (state_q == S_IDLE && req_fire) begin
      op_d  = i_req_op;
      x_d   = i_req_data;
      res_d = '0;
      err_d = ~op_legal;
    end
    if (state_q == S_DRIVE) begin
      res_d = i_alu_O;
    end
    if (state_q == S_INC) begin
      res_d = res_q + ONE;
    end
  end

  always_comb begin
    o_req_ready = rdy_q & (state_q == S_IDLE);
    o_alu_z     = 1'b0;
    o_alu_n     = 1'b0;
    o_alu_X     = '0;
    o_rsp_valid = 1'b0;
    o_rsp_data  = '0;
    o_rsp_zero  = 1'b0;
    o_rsp_neg   = 1'b0;
    o_rsp_err   = 1'b0;
    if (state_q == S_DRIVE) begin
      o_alu_X = x_q;
      unique case (op_q)
        OP_PASS: begin o_alu_z = 1'b0; o_alu_n = 1'b0; end
        OP_NOT:  begin o_alu_z = 1'b0; o_alu_n = 1'b1; end
        OP_ZERO: begin o_alu_z = 1'b1; o_alu_n = 1'b0; end
        OP_ONES: begin o_alu_z = 1'b1; o_alu_n = 1'b1; end
        OP_NEG:  begin o_alu_z = 1'b0; o_alu_n = 1'b1; end
        default: begin o_alu_z = 1'b0; o_alu_n = 1'b0; end
      endcase
    end
    if (state_q == S_RESP) begin
      o_rsp_valid = 1'b1;
      o_rsp_data  = res_q;
      o_rsp_zero  = (res_q == '0);
      o_rsp_neg   = res_q[BUS_WIDTH-1];
      o_rsp_err   = err_q;
    end
  end

endmodule

// File: tb/tb_unary_alu_sequencer.sv
// Bench for unary_alu_sequencer: directed and random ops checked
// against an arithmetic reference model and a modelled external ALU.
module tb_unary_alu_sequencer;

  localparam int W = 8;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_req_valid = 1'b0;
  logic         o_req_ready;
  logic [2:0]   i_req_op = '0;
  logic [W-1:0] i_req_data = '0;
  logic         o_alu_z;
  logic         o_alu_n;
  logic [W-1:0] o_alu_X;
  logic [W-1:0] i_alu_O;
  logic         o_rsp_valid;
  logic         i_rsp_ready = 1'b0;
  logic [W-1:0] o_rsp_data;
  logic         o_rsp_zero;
  logic         o_rsp_neg;
  logic         o_rsp_err;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  // External combinational unary ALU
  assign i_alu_O = o_alu_z ? (o_alu_n ? {W{1'b1}} : {W{1'b0}})
                           : (o_alu_n ? ~o_alu_X : o_alu_X);

  unary_alu_sequencer #(.BUS_WIDTH(W)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_op    (i_req_op),
    .i_req_data  (i_req_data),
    .o_alu_z     (o_alu_z),
    .o_alu_n     (o_alu_n),
    .o_alu_X     (o_alu_X),
    .i_alu_O     (i_alu_O),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_data  (o_rsp_data),
    .o_rsp_zero  (o_rsp_zero),
    .o_rsp_neg   (o_rsp_neg),
    .o_rsp_err   (o_rsp_err)
  );

  function automatic logic [W-1:0] ref_res(input logic [2:0] op,
                                           input logic [W-1:0] d);
    int v;
    case (op)
      3'd0: v = int'(d);
      3'd1: v = (1 << W) - 1 - int'(d);
      3'd2: v = 0;
      3'd3: v = (1 << W) - 1;
      3'd4: v = ((1 << W) - int'(d)) % (1 << W);
      default: v = 0;
    endcase
    return W'(v);
  endfunction

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    checks++;
    if ({o_req_ready, o_rsp_valid, o_alu_z, o_alu_n, o_alu_X,
         o_rsp_data, o_rsp_zero, o_rsp_neg, o_rsp_err} !== '0)
      begin
        errors++;
        $display("FAIL reset_outputs: rdy=%b vld=%b z=%b n=%b X=%h d=%h",
                 o_req_ready, o_rsp_valid, o_alu_z, o_alu_n, o_alu_X,
                 o_rsp_data);
      end
    i_rst = 1'b0;
    @(posedge i_clk);
    #1;
    checks++;
    if (o_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_rise: got %b want 1", o_req_ready);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] d,
                        input int hold);
    logic [W-1:0] er;
    logic         legal;
    logic         ez, en;
    logic [W-1:0] ex;
    int           el, lat;
    er    = ref_res(op, d);
    legal = (op <= 3'd4);
    el    = !legal ? 1 : (op == 3'd4 ? 3 : 2);
    checks++;
    if (o_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_idle: got %b want 1", o_req_ready);
    end
    i_req_valid = 1'b1;
    i_req_op    = op;
    i_req_data  = d;
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      if (o_rsp_valid === 1'b1) begin
        lat = c;
        break;
      end
      ez = legal && c == 1 && (op == 3'd2 || op == 3'd3);
      en = legal && c == 1 && (op == 3'd1 || op == 3'd3 || op == 3'd4);
      ex = (legal && c == 1) ? d : '0;
      checks++;
      if ({o_alu_z, o_alu_n, o_alu_X, o_req_ready} !== {ez, en, ex, 1'b0})
        begin
          errors++;
          $display("FAIL alu_ctrl op%0d c%0d: z=%b n=%b X=%h rdy=%b want %b %b %h 0",
                   op, c, o_alu_z, o_alu_n, o_alu_X, o_req_ready, ez, en, ex);
        end
      i_rsp_ready = 1'($urandom_range(0, 1));
      @(posedge i_clk);
      #1;
    end
    i_rsp_ready = 1'b0;
    checks++;
    if (lat !== el) begin
      errors++;
      $display("FAIL latency op%0d: got %0d want %0d (0=timeout)",
               op, lat, el);
    end
    i_req_valid = 1'b1;
    i_req_data  = W'($urandom);
    for (int h = 0; h <= hold; h++) begin
      if (h > 0) begin
        @(posedge i_clk);
        #1;
      end
      checks++;
      if ({o_rsp_valid, o_req_ready, o_rsp_data, o_rsp_zero, o_rsp_neg,
           o_rsp_err, o_alu_z, o_alu_n, o_alu_X} !==
          {1'b1, 1'b0, er, er == '0, er[W-1], !legal, 2'b00, {W{1'b0}}})
        begin
          errors++;
          $display("FAIL rsp op%0d d=%h h%0d: v=%b r=%b data=%h z=%b n=%b e=%b want data=%h z=%b n=%b e=%b",
                   op, d, h, o_rsp_valid, o_req_ready, o_rsp_data,
                   o_rsp_zero, o_rsp_neg, o_rsp_err,
                   er, er == '0, er[W-1], !legal);
        end
    end
    i_rsp_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_rsp_ready = 1'b0;
    i_req_valid = 1'b0;
    checks++;
    if ({o_rsp_valid, o_req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL rsp_release: vld=%b rdy=%b want 0 1",
               o_rsp_valid, o_req_ready);
    end
  endtask

  task automatic test_directed();
    run_op(3'd0, 8'h5A, 0);
    run_op(3'd1, 8'h0F, 0);
    run_op(3'd2, 8'hFF, 0);
    run_op(3'd3, 8'h12, 0);
    run_op(3'd4, 8'h01, 0);
    run_op(3'd4, 8'h00, 0);
    run_op(3'd4, 8'h80, 0);
    run_op(3'd6, 8'h33, 0);
  endtask

  task automatic test_backpressure();
    run_op(3'd1, 8'hC3, 5);
    run_op(3'd0, 8'h00, 0);
    run_op(3'd7, 8'hFF, 3);
  endtask

  task automatic test_abort();
    i_req_valid = 1'b1;
    i_req_op    = 3'd4;
    i_req_data  = 8'h01;
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    checks++;
    if ({o_alu_z, o_alu_n, o_alu_X} !== {2'b01, 8'h01}) begin
      errors++;
      $display("FAIL abort_drive: z=%b n=%b X=%h want 0 1 01",
               o_alu_z, o_alu_n, o_alu_X);
    end
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    checks++;
    if ({o_req_ready, o_rsp_valid, o_alu_z, o_alu_n, o_alu_X,
         o_rsp_data, o_rsp_zero, o_rsp_neg, o_rsp_err} !== '0)
      begin
        errors++;
        $display("FAIL abort_outputs: rdy=%b vld=%b z=%b n=%b X=%h d=%h",
                 o_req_ready, o_rsp_valid, o_alu_z, o_alu_n, o_alu_X,
                 o_rsp_data);
      end
    for (int c = 0; c < 3; c++) begin
      @(posedge i_clk);
      #1;
      checks++;
      if ({o_rsp_valid, o_req_ready} !== 2'b01) begin
        errors++;
        $display("FAIL abort_no_rsp c%0d: vld=%b rdy=%b want 0 1",
                 c, o_rsp_valid, o_req_ready);
      end
    end
    run_op(3'd0, 8'hA5, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      run_op(3'($urandom_range(0, 7)), W'($urandom),
             int'($urandom_range(0, 3)));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
